// File: rtl/rv_counter_unit.sv
// Machine counter/timer unit: cycle, time (prescaled), instret, HPM counters, mtimecmp, inhibit.
// Optional sticky HPM overflow bits with interrupt when RV_COUNTER_OVF_IRQ_EN is defined.
module rv_counter_unit #(
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned NUM_HPM   = 4,
  parameter int unsigned TICK_DIV  = 128
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        instret_en,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0]    hpm_event,
  input  logic [3:0]                                  csr_sel,
  input  logic                                        csr_upper,
  input  logic                                        csr_we,
  input  logic [31:0]                                 csr_wdata,
  output logic [31:0]                                 csr_rdata,
  output logic                                        timer_irq,
  output logic                                        ovf_irq
);

  localparam int unsigned HW    = CNT_WIDTH - 32;
  localparam int unsigned HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam int unsigned INH_W = 3 + NUM_HPM;
  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_WIDTH-1:0] cycle_q, cycle_nxt;
  logic [CNT_WIDTH-1:0] time_q, time_nxt;
  logic [CNT_WIDTH-1:0] instret_q, instret_nxt;
  logic [CNT_WIDTH-1:0] mtimecmp_q, mtimecmp_nxt;
  logic [CNT_WIDTH-1:0] hpm_q   [HPM_N];
  logic [CNT_WIDTH-1:0] hpm_nxt [HPM_N];
  logic [INH_W-1:0]     inh_q, inh_nxt;
  logic [PW-1:0]        presc_q, presc_nxt;
  logic                 tick;
  logic                 wr_lo, wr_hi;
  logic [31:0]          ovf_rd;

  // Write wins over increment; an upper write keeps the low half counting but drops its carry.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic inc, input logic wlo,
                                                    input logic whi, input logic [31:0] wd);
    logic [CNT_WIDTH-1:0] sum;
    sum = cur + CNT_WIDTH'(inc);
    if (wlo)      return {cur[CNT_WIDTH-1:32], wd};
    else if (whi) return {wd[HW-1:0], sum[31:0]};
    return sum;
  endfunction

  // Next-state for all counters, prescaler and inhibit.
  always_comb begin
    wr_lo     = csr_we & ~csr_upper;
    wr_hi     = csr_we & csr_upper;
    tick      = ~inh_q[1] && (presc_q == PW'(TICK_DIV - 1));
    presc_nxt = presc_q;
    if (!inh_q[1]) presc_nxt = tick ? '0 : presc_q + PW'(1);

    cycle_nxt    = cnt_next(cycle_q, ~inh_q[0], wr_lo && csr_sel == 4'd0,
                            wr_hi && csr_sel == 4'd0, csr_wdata);
    time_nxt     = cnt_next(time_q, tick, wr_lo && csr_sel == 4'd1,
                            wr_hi && csr_sel == 4'd1, csr_wdata);
    instret_nxt  = cnt_next(instret_q, instret_en & ~inh_q[2], wr_lo && csr_sel == 4'd2,
                            wr_hi && csr_sel == 4'd2, csr_wdata);
    mtimecmp_nxt = cnt_next(mtimecmp_q, 1'b0, wr_lo && csr_sel == 4'd13,
                            wr_hi && csr_sel == 4'd13, csr_wdata);

    for (int unsigned k = 0; k < HPM_N; k++) hpm_nxt[k] = '0;
    for (int unsigned k = 0; k < NUM_HPM; k++) begin
      hpm_nxt[k] = cnt_next(hpm_q[k], hpm_event[k] & ~inh_q[3+k],
                            wr_lo && csr_sel == 4'(3 + k),
                            wr_hi && csr_sel == 4'(3 + k), csr_wdata);
    end

    inh_nxt = inh_q;
    if (csr_we && csr_sel == 4'd14) inh_nxt = csr_wdata[INH_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q    <= '0;
      time_q     <= '0;
      instret_q  <= '0;
      mtimecmp_q <= '1;
      inh_q      <= '0;
      presc_q    <= '0;
      timer_irq  <= 1'b0;
      for (int unsigned k = 0; k < HPM_N; k++) hpm_q[k] <= '0;
    end else begin
      cycle_q    <= cycle_nxt;
      time_q     <= time_nxt;
      instret_q  <= instret_nxt;
      mtimecmp_q <= mtimecmp_nxt;
      inh_q      <= inh_nxt;
      presc_q    <= presc_nxt;
      timer_irq  <= (time_q >= mtimecmp_q);
      for (int unsigned k = 0; k < HPM_N; k++) hpm_q[k] <= hpm_nxt[k];
    end
  end

`ifdef RV_COUNTER_OVF_IRQ_EN
  logic [HPM_N-1:0] ovf_q, ovf_nxt, ovf_set;
  logic             ovf_irq_q;

  // Sticky overflow on increment-driven wrap; W1C, with set winning over clear.
  always_comb begin
    ovf_set = '0;
    for (int unsigned k = 0; k < NUM_HPM; k++) begin
      if (hpm_event[k] && !inh_q[3+k] && (&hpm_q[k]) && !(csr_we && csr_sel == 4'(3 + k)))
        ovf_set[k] = 1'b1;
    end
    ovf_nxt = ovf_q;
    if (csr_we && csr_sel == 4'd15) ovf_nxt = ovf_q & ~csr_wdata[HPM_N-1:0];
    ovf_nxt = ovf_nxt | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= '0;
      ovf_irq_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_nxt;
      ovf_irq_q <= |ovf_q;
    end
  end

  assign ovf_rd  = 32'(ovf_q);
  assign ovf_irq = ovf_irq_q;
`else
  assign ovf_rd  = '0;
  assign ovf_irq = 1'b0;
`endif

  // Read mux: counters honour csr_upper, status registers are flat.
  logic [CNT_WIDTH-1:0] cnt_rd;
  logic                 is_cnt;
  always_comb begin
    cnt_rd    = '0;
    is_cnt    = 1'b0;
    csr_rdata = '0;
    case (csr_sel)
      4'd0:  begin cnt_rd = cycle_q;    is_cnt = 1'b1; end
      4'd1:  begin cnt_rd = time_q;     is_cnt = 1'b1; end
      4'd2:  begin cnt_rd = instret_q;  is_cnt = 1'b1; end
      4'd13: begin cnt_rd = mtimecmp_q; is_cnt = 1'b1; end
      4'd14: csr_rdata = 32'(inh_q);
      4'd15: csr_rdata = ovf_rd;
      default: begin
        for (int unsigned k = 0; k < NUM_HPM; k++) begin
          if (csr_sel == 4'(3 + k)) begin
            cnt_rd = hpm_q[k];
            is_cnt = 1'b1;
          end
        end
      end
    endcase
    if (is_cnt) csr_rdata = csr_upper ? 32'(cnt_rd[CNT_WIDTH-1:32]) : cnt_rd[31:0];
  end

endmodule

// File: tb/tb_rv_counter_unit.sv
// Directed bench for rv_counter_unit: dut0 uses TICK_DIV=128, dut1 uses TICK_DIV=1 for the timer compare.
module tb_rv_counter_unit;

`ifdef RV_COUNTER_OVF_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instret_en;
  logic [3:0]  hpm_event;
  logic [3:0]  csr_sel;
  logic        csr_upper;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] rdata0, rdata1;
  logic        tirq0, tirq1, oirq0, oirq1;

  int n_checks = 0;
  int n_fail   = 0;
  bit found;

  always #10 clk = ~clk;

  rv_counter_unit #(.CNT_WIDTH(64), .NUM_HPM(4), .TICK_DIV(128)) dut0 (
    .clk(clk), .rst_n(rst_n), .instret_en(instret_en), .hpm_event(hpm_event),
    .csr_sel(csr_sel), .csr_upper(csr_upper), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(rdata0), .timer_irq(tirq0), .ovf_irq(oirq0));

  rv_counter_unit #(.CNT_WIDTH(64), .NUM_HPM(4), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .instret_en(instret_en), .hpm_event(hpm_event),
    .csr_sel(csr_sel), .csr_upper(csr_upper), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(rdata1), .timer_irq(tirq1), .ovf_irq(oirq1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] s, input logic up);
    csr_sel   = s;
    csr_upper = up;
    #1;
  endtask

  task automatic wr(input logic [3:0] s, input logic up, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_sel   = s;
    csr_upper = up;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; instret_en = 1'b0; hpm_event = '0;
    csr_sel = '0; csr_upper = 1'b0; csr_we = 1'b0; csr_wdata = '0;
    tick(); tick();

    // Reset state (held in reset, so clock edges do not matter)
    rd(4'd0, 1'b0);  check("rst_cycle", rdata0, 32'h0);
    rd(4'd1, 1'b0);  check("rst_time", rdata0, 32'h0);
    rd(4'd2, 1'b0);  check("rst_instret", rdata0, 32'h0);
    rd(4'd13, 1'b0); check("rst_mtimecmp_lo", rdata0, 32'hFFFF_FFFF);
    rd(4'd13, 1'b1); check("rst_mtimecmp_hi", rdata0, 32'hFFFF_FFFF);
    rd(4'd14, 1'b0); check("rst_inhibit", rdata0, 32'h0);
    rd(4'd15, 1'b0); check("rst_ovf", rdata0, 32'h0);
    check("rst_timer_irq", 32'(tirq0), 32'h0);
    check("rst_ovf_irq", 32'(oirq0), 32'h0);
    tick();
    rst_n = 1'b1;

    // Free run, 300 clocks
    repeat (300) tick();
    rd(4'd0, 1'b0); check("run_cycle_lo", rdata0, 32'd300);
    rd(4'd0, 1'b1); check("run_cycle_hi", rdata0, 32'd0);
    rd(4'd1, 1'b0); check("run_time", rdata0, 32'd2);
    check("run_timer_irq", 32'(tirq0), 32'h0);

    // Lower write then carry into the upper half
    wr(4'd0, 1'b0, 32'hFFFF_FFFE);
    rd(4'd0, 1'b0); check("wr_cycle_lo", rdata0, 32'hFFFF_FFFE);
    rd(4'd0, 1'b1); check("wr_cycle_hi", rdata0, 32'h0);
    tick();
    rd(4'd0, 1'b0); check("carry1_lo", rdata0, 32'hFFFF_FFFF);
    tick();
    rd(4'd0, 1'b0); check("carry2_lo", rdata0, 32'h0);
    rd(4'd0, 1'b1); check("carry2_hi", rdata0, 32'h1);
    tick();
    rd(4'd0, 1'b0); check("carry3_lo", rdata0, 32'h1);
    rd(4'd0, 1'b1); check("carry3_hi", rdata0, 32'h1);
    // Upper write: lower keeps counting
    wr(4'd0, 1'b1, 32'h5);
    rd(4'd0, 1'b0); check("uwr_cycle_lo", rdata0, 32'h2);
    rd(4'd0, 1'b1); check("uwr_cycle_hi", rdata0, 32'h5);

    // Inhibit of instret
    wr(4'd14, 1'b0, 32'h4);
    rd(4'd14, 1'b0); check("inh_read", rdata0, 32'h4);
    instret_en = 1'b1; repeat (10) tick(); instret_en = 1'b0;
    rd(4'd2, 1'b0); check("instret_inhibited", rdata0, 32'h0);
    wr(4'd14, 1'b0, 32'h0);
    instret_en = 1'b1; repeat (5) tick(); instret_en = 1'b0;
    rd(4'd2, 1'b0); check("instret_count", rdata0, 32'h5);
    wr(4'd14, 1'b0, 32'hFFFF_FFFF);
    rd(4'd14, 1'b0); check("inh_mask", rdata0, 32'h7F);
    rd(4'd14, 1'b1); check("inh_mask_upper", rdata0, 32'h7F);
    wr(4'd14, 1'b0, 32'h1);
    wr(4'd0, 1'b0, 32'h100);
    repeat (3) tick();
    rd(4'd0, 1'b0); check("cycle_inhibited", rdata0, 32'h100);
    wr(4'd14, 1'b0, 32'h0);

    // HPM write priority and unimplemented selects
    hpm_event = 4'b0001;
    wr(4'd3, 1'b0, 32'h7);
    hpm_event = 4'b0000;
    rd(4'd3, 1'b0); check("hpm0_wr_prio", rdata0, 32'h7);
    hpm_event = 4'b0001; tick(); tick(); hpm_event = 4'b0000;
    rd(4'd3, 1'b0); check("hpm0_count", rdata0, 32'h9);
    wr(4'd9, 1'b0, 32'h55);
    rd(4'd9, 1'b0);  check("sel9_lo", rdata0, 32'h0);
    rd(4'd9, 1'b1);  check("sel9_hi", rdata0, 32'h0);
    rd(4'd12, 1'b0); check("sel12_lo", rdata0, 32'h0);

    // Timer compare on dut1 (time +1 per clk)
    wr(4'd14, 1'b0, 32'h2);
    wr(4'd1, 1'b0, 32'h0);
    wr(4'd1, 1'b1, 32'h0);
    wr(4'd13, 1'b1, 32'h0);
    wr(4'd13, 1'b0, 32'h3);
    rd(4'd1, 1'b0); check("t1_time_frozen", rdata1, 32'h0);
    check("t1_irq_low", 32'(tirq1), 32'h0);
    wr(4'd14, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      rd(4'd1, 1'b0);
      if (rdata1 == 32'd3) begin
        found = 1'b1;
        check("t1_irq_at_eq", 32'(tirq1), 32'h0);
        tick();
        check("t1_irq_rise", 32'(tirq1), 32'h1);
      end else begin
        tick();
      end
    end
    check("t1_time_reached", 32'(found), 32'h1);
    wr(4'd13, 1'b0, 32'd100);
    check("t1_irq_hold", 32'(tirq1), 32'h1);
    tick();
    check("t1_irq_drop", 32'(tirq1), 32'h0);

    // HPM overflow
    wr(4'd4, 1'b0, 32'hFFFF_FFFF);
    wr(4'd4, 1'b1, 32'hFFFF_FFFF);
    rd(4'd4, 1'b0); check("hpm1_load_lo", rdata0, 32'hFFFF_FFFF);
    rd(4'd4, 1'b1); check("hpm1_load_hi", rdata0, 32'hFFFF_FFFF);
    check("ovf_irq_pre", 32'(oirq0), 32'h0);
    hpm_event = 4'b0010; tick(); hpm_event = 4'b0000;
    rd(4'd4, 1'b0);  check("hpm1_wrap_lo", rdata0, 32'h0);
    rd(4'd4, 1'b1);  check("hpm1_wrap_hi", rdata0, 32'h0);
    rd(4'd15, 1'b0); check("ovf_status", rdata0, OVF_EN ? 32'h2 : 32'h0);
    check("ovf_irq_lag", 32'(oirq0), 32'h0);
    tick();
    check("ovf_irq_set", 32'(oirq0), OVF_EN ? 32'h1 : 32'h0);
    wr(4'd15, 1'b0, 32'h2);
    check("ovf_irq_clr_lag", 32'(oirq0), OVF_EN ? 32'h1 : 32'h0);
    rd(4'd15, 1'b0); check("ovf_status_clr", rdata0, 32'h0);
    tick();
    check("ovf_irq_clr", 32'(oirq0), 32'h0);

    // Asynchronous reset mid-cycle
    tick();
    #3 rst_n = 1'b0;
    #1;
    rd(4'd0, 1'b0);  check("arst_cycle", rdata0, 32'h0);
    rd(4'd2, 1'b0);  check("arst_instret", rdata0, 32'h0);
    rd(4'd13, 1'b0); check("arst_mtimecmp", rdata0, 32'hFFFF_FFFF);
    rd(4'd4, 1'b1);  check("arst_hpm1_hi", rdata0, 32'h0);
    check("arst_timer_irq", 32'(tirq1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
